// File: rtl/fphub_div_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fphub_div_pkg
// Brief   : Shared types for the HUB FP divider request sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package fphub_div_pkg;

    localparam int M  = 23;
    localparam int E  = 8;
    localparam int TW = 4;
    localparam int T  = M + E;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [T:0]    x;
        logic [T:0]    d;
        logic [TW-1:0] tag;
    } div_req_t;

endpackage
`default_nettype wire

// File: rtl/fphub_req_fifo.sv
`default_nettype none
// ============================================================================
// Module  : fphub_req_fifo
// Brief   : Synchronous request FIFO; head is read straight from storage regs.
// Revision: 1.0 - initial release
// ============================================================================
module fphub_req_fifo
    import fphub_div_pkg::*;
#(
    parameter int WIDTH = $bits(div_req_t),
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int            c_aw    = $clog2(DEPTH);
    localparam logic [c_aw:0] c_depth = (c_aw + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == c_depth);
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign head      = r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/fphub_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : fphub_div_sequencer
// Brief   : Buffers divide requests and issues them one at a time to the SRT
//           divider, with a watchdog for a divider that never finishes.
// Revision: 1.0 - initial release
// ============================================================================
module fphub_div_sequencer
    import fphub_div_pkg::*;
#(
    parameter int M       = 23,
    parameter int E       = 8,
    parameter int DEPTH   = 4,
    parameter int TW      = 4,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_l,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [M+E:0]    in_x,
    input  logic [M+E:0]    in_d,
    input  logic [TW-1:0]   in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [M+E:0]    out_res,
    output logic [TW-1:0]   out_tag,
    output logic            out_special,
    output logic            out_err,
    output logic            div_start,
    output logic [M+E:0]    div_x,
    output logic [M+E:0]    div_d,
    input  logic [M+E:0]    div_res,
    input  logic            div_finish,
    input  logic            div_special
);

    localparam int c_w   = M + E + 1;
    localparam int c_fw  = 2 * c_w + TW;
    localparam int c_wdw = $clog2(TIMEOUT + 1);

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    logic [c_fw-1:0]  w_fifo_head;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_load;
    logic             w_capture;
    logic             w_timeout;
    logic             w_release;

    logic [c_w-1:0]   r_div_x;
    logic [c_w-1:0]   r_div_d;
    logic [TW-1:0]    r_tag;
    logic             r_special;
    logic [c_wdw-1:0] r_wd;
    logic [c_w-1:0]   r_out_res;
    logic             r_out_special;
    logic             r_out_err;
    logic             r_out_valid;
    logic [7:0]       r_stray;

    assign in_ready    = !w_full;
    assign w_push      = in_valid && in_ready;
    assign w_pop       = w_capture || w_timeout;
    assign div_start   = (r_state == S_ISSUE);
    assign div_x       = r_div_x;
    assign div_d       = r_div_d;
    assign out_valid   = r_out_valid;
    assign out_res     = r_out_res;
    assign out_tag     = r_tag;
    assign out_special = r_out_special;
    assign out_err     = r_out_err;

    fphub_req_fifo #(
        .WIDTH (c_fw),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_l     (rst_l),
        .push      (w_push),
        .push_data ({in_x, in_d, in_tag}),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .head      (w_fifo_head)
    );

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                // A finish on the final watchdog cycle still wins.
                if (div_finish) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_HOLD;
                end else if (r_wd == c_wdw'(TIMEOUT - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_release   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_div_x       <= '0;
            r_div_d       <= '0;
            r_tag         <= '0;
            r_special     <= 1'b0;
            r_wd          <= '0;
            r_out_res     <= '0;
            r_out_special <= 1'b0;
            r_out_err     <= 1'b0;
            r_out_valid   <= 1'b0;
            r_stray       <= '0;
        end else begin
            if (w_load) {r_div_x, r_div_d, r_tag} <= w_fifo_head;

            if (r_state == S_ISSUE) begin
                r_special <= div_special;
                r_wd      <= '0;
            end else if (r_state == S_WAIT && !div_finish) begin
                r_wd <= r_wd + 1'b1;
            end

            if (w_capture) begin
                r_out_res     <= div_res;
                r_out_special <= r_special;
                r_out_err     <= 1'b0;
                r_out_valid   <= 1'b1;
            end else if (w_timeout) begin
                r_out_res     <= '0;
                r_out_special <= 1'b0;
                r_out_err     <= 1'b1;
                r_out_valid   <= 1'b1;
            end else if (w_release) begin
                r_out_valid <= 1'b0;
                r_out_err   <= 1'b0;
            end

            if (div_finish && r_state != S_WAIT && r_stray != 8'hFF)
                r_stray <= r_stray + 8'd1;
        end
    end

endmodule
`default_nettype wire
